subta_pipe: RTL and testbench
=============================

SUBTA_PIPE -- requirements
Module: subta_pipe

Interface
REQ-001 The block SHALL have the port: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port: reset  in  1  asynchronous active-low reset (0 = reset).
REQ-003 The block SHALL have the port: scan_in0  in  1  scan chain input, reserved for DFT insertion.
REQ-004 The block SHALL have the port: scan_en  in  1  scan enable, reserved for DFT insertion.
REQ-005 The block SHALL have the port: scan_out0  out  1  scan chain output, driven 0 pre-DFT.
REQ-006 The block SHALL have the port: in_valid  in  1  an SL/SE sample pair is offered.
REQ-007 The block SHALL have the port: in_ready  out  1  the block can accept a pair this cycle.
REQ-008 The block SHALL have the port: SL  in  14  linear input signal, two's complement.
REQ-009 The block SHALL have the port: SE  in  15  signal estimate, two's complement.
REQ-010 The block SHALL have the port: out_valid  out  1  D at the FIFO head is valid.
REQ-011 The block SHALL have the port: out_ready  in  1  the consumer takes D this cycle.
REQ-012 The block SHALL have the port: D  out  16  difference signal, two's complement.
REQ-013 The block SHALL have the port: DSM  out  16  D in sign-magnitude form (sign bit, then 15-bit magnitude); present only with SUBTA_PIPE_SM_EN.

Function
REQ-014 Handshake rule: an input pair SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Handshake rule: an output SHALL be popped on a rising edge where out_valid=1 and out_ready=1.
REQ-016 Arithmetic: SL and SE SHALL be sign-extended to 16 bits as SLI and SEI, and D SHALL equal (SLI - SEI) mod 2^16, computed at acceptance.
REQ-017 Storage: computed D values SHALL be held in a 2-entry output FIFO with in-order delivery.
REQ-018 States: the FIFO SHALL track exactly three states, EMPTY, ONE and FULL.
REQ-019 Transitions: EMPTY SHALL go to ONE on push; ONE SHALL go to FULL on push without pop, to EMPTY on pop without push, and stay ONE on push+pop; FULL SHALL go to ONE on pop.
REQ-020 Output signals: out_valid SHALL be 1 in ONE or FULL, and D SHALL always present the FIFO head.
REQ-021 in_ready SHALL be registered, with no combinational path from out_ready, and SHALL equal 1 unless the state is FULL.
REQ-022 Latency: a pair accepted at edge N SHALL be presented with out_valid=1 after edge N, i.e. 1 cycle.
REQ-023 Throughput: continuous streaming with out_ready=1 SHALL sustain one sample per cycle.
REQ-024 Simultaneous push and pop in ONE SHALL replace the head with the new sample and SHALL drop no data.
REQ-025 A push attempted while FULL cannot occur, because in_ready=0.
REQ-026 A pop attempted while EMPTY SHALL be ignored.
REQ-027 Inputs are bounded to |D| <= 24575, so D=16'h8000 SHALL never arise and no saturation is performed.
REQ-028 D and DSM SHALL hold their value while out_valid=1 and out_ready=0.

Reset
REQ-029 Asserting reset SHALL immediately force the state to EMPTY, out_valid=0, in_ready=1, D=0, DSM=0 and scan_out0=0.
REQ-030 Reset asserted mid-stream SHALL discard all FIFO contents, and no stale sample SHALL appear after release.
REQ-031 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-032 With macro SUBTA_PIPE_SM_EN defined, the DSM port and its storage SHALL exist, with DSM[15]=D[15] and DSM[14:0]=|D|.
REQ-033 Without SUBTA_PIPE_SM_EN, the DSM port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-034 The shared package mcac_pkg SHALL hold SL_W=14, SE_W=15, D_W=16, the FIFO-state enumeration (EMPTY/ONE/FULL) and the bound constant DMAX=24575.
REQ-035 One sub-module, subta_fifo2 (the 2-entry FIFO plus state machine, parameterised by width), SHALL be used, and the subtractor SHALL be top-level logic.

Verification
REQ-036 The bench SHALL cover: SL=14'h0010, SE=15'h0008, out_ready=1 -> D=16'h0008 one cycle after acceptance, DSM=16'h0008.
REQ-037 The bench SHALL cover: SL=14'h3FFF, SE=15'h0001 -> D=16'hFFFE, DSM=16'h8002.
REQ-038 The bench SHALL cover: SL=14'h2000, SE=15'h3FFF -> D=16'hA001, and SL=14'h1FFF, SE=15'h4000 -> D=16'h5FFF.
REQ-039 The bench SHALL cover: out_ready=0 with 3 offered pairs -> 2 accepted, in_ready=0 after the second; then out_ready=1 -> outputs in order, the third is accepted, and no loss or duplicate occurs.
REQ-040 The bench SHALL cover: 100 random pairs with out_ready toggling randomly -> every D matches the reference model (SLI-SEI) mod 2^16, in order.
REQ-041 The bench SHALL cover: reset asserted while FULL -> out_valid=0 and in_ready=1 immediately, and after release the first output is the first post-reset input.

Source files
------------

// File: rtl/mcac_pkg.sv
// -----------------------------------------------------------------------------
// mcac_pkg -- shared constants and types for the subtractor pipeline.
//   SL_W / SE_W / D_W : widths of the linear input, the signal estimate and the
//                       difference signal.
//   DMAX              : largest |D| the input ranges can produce; with it D can
//                       never be 16'h8000, so the sign-magnitude form always fits.
//   fifo_state_t      : occupancy of the 2-entry output FIFO.
//   to_sm()           : two's complement -> sign-magnitude conversion.
// -----------------------------------------------------------------------------
package mcac_pkg;

  localparam int SL_W  = 14;
  localparam int SE_W  = 15;
  localparam int D_W   = 16;
  localparam int DMAX  = 24575;
  // Magnitude field width that covers every legal |D|.
  localparam int MAG_W = $clog2(DMAX + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  // Sign bit followed by the magnitude. The bounded input range guarantees
  // the magnitude of a negative value fits in MAG_W bits.
  function automatic logic [D_W-1:0] to_sm(input logic [D_W-1:0] d);
    logic [D_W-1:0] mag;
    mag = d[D_W-1] ? (-d) : d;
    return {d[D_W-1], mag[MAG_W-1:0]};
  endfunction

endpackage

// File: rtl/subta_fifo2.sv
// -----------------------------------------------------------------------------
// subta_fifo2 -- 2-entry in-order FIFO with a valid/ready interface on both
// sides and an explicit EMPTY/ONE/FULL state machine.
//   clk, reset (async, active low)
//   in_valid / in_ready / din     : push side; in_ready is a register output
//   out_valid / out_ready / dout  : pop side; dout always shows the head entry
// Parameter WIDTH sets the data width.
// -----------------------------------------------------------------------------
module subta_fifo2
  import mcac_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  fifo_state_t      state_reg, state_next;
  logic             in_ready_reg;
  logic [WIDTH-1:0] head_reg, tail_reg;
  logic             push, pop;

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid & out_ready;   // a pop while EMPTY is ignored

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (!push && pop) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (state_reg != EMPTY);
    in_ready  = in_ready_reg;
    dout      = head_reg;
  end

  // in_ready is looked ahead from the next state so it is a plain flop with
  // no combinational path from out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_reg <= 1'b1;
    end else begin
      in_ready_reg <= (state_next != FULL);
    end
  end

  // Storage: head is the entry on dout, tail is only used while FULL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      case (state_reg)
        EMPTY: if (push) head_reg <= din;
        ONE: begin
          // push+pop replaces the head; push alone queues behind it
          if (push && pop) head_reg <= din;
          else if (push)   tail_reg <= din;
        end
        FULL:    if (pop) head_reg <= tail_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/subta_pipe.sv
// -----------------------------------------------------------------------------
// subta_pipe -- computes D = SL - SE (both sign-extended to 16 bits) at input
// acceptance and delivers the results through a 2-entry output FIFO.
//   clk, reset (async, active low)
//   scan_in0, scan_en, scan_out0 : DFT placeholders, scan_out0 tied low
//   in_valid / in_ready / SL / SE : input pair handshake
//   out_valid / out_ready / D     : difference output handshake
//   DSM                           : D in sign-magnitude form, only when the
//                                   macro SUBTA_PIPE_SM_EN is defined
// -----------------------------------------------------------------------------
module subta_pipe
  import mcac_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_en,
  output logic            scan_out0,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SL_W-1:0] SL,
  input  logic [SE_W-1:0] SE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [D_W-1:0]  D
`ifdef SUBTA_PIPE_SM_EN
  ,
  output logic [D_W-1:0]  DSM
`endif
);

  logic [D_W-1:0] sli, sei, d_calc;
  logic           unused_scan;

  assign scan_out0   = 1'b0;
  assign unused_scan = scan_in0 ^ scan_en;

  assign sli    = {{(D_W-SL_W){SL[SL_W-1]}}, SL};
  assign sei    = {{(D_W-SE_W){SE[SE_W-1]}}, SE};
  assign d_calc = sli - sei;   // wraps mod 2^16, no saturation

`ifdef SUBTA_PIPE_SM_EN
  // Both forms travel together through one FIFO so they stay paired.
  logic [2*D_W-1:0] fifo_din, fifo_dout;

  assign fifo_din = {d_calc, to_sm(d_calc)};
  assign D        = fifo_dout[2*D_W-1:D_W];
  assign DSM      = fifo_dout[D_W-1:0];

  subta_fifo2 #(.WIDTH(2*D_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (fifo_din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (fifo_dout)
  );
`else
  subta_fifo2 #(.WIDTH(D_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (d_calc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (D)
  );
`endif

endmodule

// File: tb/tb_subta_pipe.sv
// -----------------------------------------------------------------------------
// tb_subta_pipe -- self-checking bench for subta_pipe. A queue-based reference
// model tracks the expected FIFO contents; directed literal vectors pin it.
// Build with SUBTA_PIPE_SM_EN defined to also exercise DSM.
// -----------------------------------------------------------------------------
module tb_subta_pipe;
  import mcac_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scan_in0 = 1'b0;
  logic        scan_en = 1'b0;
  logic        scan_out0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] SL = '0;
  logic [14:0] SE = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] D;
`ifdef SUBTA_PIPE_SM_EN
  logic [15:0] DSM;
`endif

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int accepts = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  subta_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .scan_out0 (scan_out0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SL        (SL),
    .SE        (SE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
`ifdef SUBTA_PIPE_SM_EN
    ,
    .DSM       (DSM)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed integer difference, kept to 16 bits.
  function automatic logic [15:0] ref_d(input logic [13:0] sl, input logic [14:0] se);
    int a, b;
    a = $signed(sl);
    b = $signed(se);
    return 16'(a - b);
  endfunction

  function automatic logic [15:0] ref_sm(input logic [15:0] d);
    int v;
    v = $signed(d);
    if (v < 0) v = -v;
    return {d[15], 15'(v)};
  endfunction

  // Model and compare process: sampled on the falling edge, it checks the
  // outputs against the model and then applies the handshakes that the next
  // rising edge will perform.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_D", 32'(D), 32'd0);
      chk("rst_scan_out0", 32'(scan_out0), 32'd0);
    end else begin
      chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("m_scan_out0", 32'(scan_out0), 32'd0);
      if (q.size() > 0) begin
        chk("m_D", 32'(D), 32'(q[0]));
`ifdef SUBTA_PIPE_SM_EN
        chk("m_DSM", 32'(DSM), 32'(ref_sm(q[0])));
`endif
      end
      if (out_valid && out_ready && q.size() > 0) begin
        $display("pop #%0d D=%h", pops, q[0]);
        void'(q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_d(SL, SE));
        accepts++;
      end
    end
  end

  // Offer a pair at posedge+1 and hold it until accepted; returns edges waited.
  task automatic send(input logic [13:0] sl, input logic [14:0] se, output int waits);
    bit acc;
    waits = 0;
    in_valid = 1'b1;
    SL = sl;
    SE = se;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 50);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [13:0] sl, input logic [14:0] se,
                          input logic [15:0] exp_d, input logic [15:0] exp_sm);
    int w;
    out_ready = 1'b1;
    send(sl, se, w);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_D"}, 32'(D), 32'(exp_d));
`ifdef SUBTA_PIPE_SM_EN
    chk({name, "_DSM"}, 32'(DSM), 32'(exp_sm));
`else
    if (exp_sm != ref_sm(exp_d)) chk({name, "_sm_model"}, 32'(ref_sm(exp_d)), 32'(exp_sm));
`endif
    @(posedge clk);
    #1;
    chk({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int pops0;
    bit done;
    logic [13:0] rsl;
    logic [14:0] rse;
    int diff;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_D", 32'(D), 32'd0);

    // Release mid-cycle; the first edge afterwards must accept.
    @(posedge clk);
    #3;
    reset = 1'b1;
    out_ready = 1'b1;
    send(14'h0010, 15'h0008, w);
    chk("first_accept_edges", 32'(w), 32'd1);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_D", 32'(D), 32'h0008);
    @(posedge clk);
    #1;

    // Directed arithmetic vectors
    directed("v1", 14'h0010, 15'h0008, 16'h0008, 16'h0008);
    directed("v2", 14'h3FFF, 15'h0001, 16'hFFFE, 16'h8002);
    directed("v3", 14'h2000, 15'h3FFF, 16'hA001, 16'hDFFF);
    directed("v4", 14'h1FFF, 15'h4000, 16'h5FFF, 16'h5FFF);

    // Backpressure: three pairs offered with out_ready=0
    out_ready = 1'b0;
    in_valid = 1'b1;
    SL = 14'h0005; SE = 15'h0001;
    @(posedge clk); #1;
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    chk("bp_D0", 32'(D), 32'h0004);
    SL = 14'h3FF0; SE = 15'h0010;
    @(posedge clk); #1;
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_valid_full", 32'(out_valid), 32'd1);
    chk("bp_D0_hold", 32'(D), 32'h0004);
    SL = 14'd100; SE = 15'h7FFF;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_ready_stall", 32'(in_ready), 32'd0);
    chk("bp_D0_stall", 32'(D), 32'h0004);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_D1", 32'(D), 32'hFFE0);
    chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_D2", 32'(D), 32'h0065);
    chk("bp_valid_D2", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Random stream with random backpressure
    pops0 = pops;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          do begin
            rsl = 14'($urandom);
            rse = 15'($urandom);
            diff = int'($signed(rsl)) - int'($signed(rse));
          end while (diff > DMAX || diff < -DMAX);
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send(rsl, rse, w);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_pop_count", 32'(pops - pops0), 32'd100);
    chk("rand_drained", 32'(out_valid), 32'd0);
    chk("rand_balance", 32'(accepts - pops), 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    send(14'h0011, 15'h0001, w);
    send(14'h0022, 15'h0002, w);
    chk("rf_full_ready", 32'(in_ready), 32'd0);
    chk("rf_full_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rf_async_valid", 32'(out_valid), 32'd0);
    chk("rf_async_ready", 32'(in_ready), 32'd1);
    chk("rf_async_D", 32'(D), 32'd0);
`ifdef SUBTA_PIPE_SM_EN
    chk("rf_async_DSM", 32'(DSM), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    out_ready = 1'b1;
    send(14'h0123, 15'h0021, w);
    chk("rf_first_accept_edges", 32'(w), 32'd1);
    chk("rf_first_valid", 32'(out_valid), 32'd1);
    chk("rf_first_D", 32'(D), 32'h0102);
    @(posedge clk); #1;
    chk("rf_no_stale", 32'(out_valid), 32'd0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
